// File: rtl/rom_cache_pkg.sv
// Shared types and defaults for the direct-mapped ROM read cache.
// Optional statistics counters are enabled with ROM_CACHE_STATS_EN.
package rom_cache_pkg;

   localparam int DEF_IDX_BITS  = 6;
   localparam int DEF_ADDR_BITS = 23;

   typedef enum logic [2:0] {
      DRAIN,
      FLUSH,
      IDLE,
      MISS,
      RESP
   } state_t;

   function automatic int tagWidth(input int idxBits, input int addrBits);
      return addrBits - idxBits;
   endfunction

endpackage

// File: rtl/rom_read_cache_if.sv
// CPU, snoop and SDRAM romrd signals of the ROM read cache.
// ROM_CACHE_STATS_EN adds the hit/miss counters to the bundle.
interface rom_read_cache_if
   import rom_cache_pkg::*;
   #(parameter int ADDR_BITS = DEF_ADDR_BITS) ();

   logic                 cpu_rd;
   logic [ADDR_BITS-1:0] cpu_a;
   logic [15:0]          cpu_q;
   logic                 cpu_valid;
   logic                 cpu_busy;
   logic                 flush;
   logic                 snoop_we;
   logic [ADDR_BITS-1:0] snoop_a;
   logic                 romrd_req;
   logic                 romrd_ack;
   logic [ADDR_BITS-1:0] romrd_a;
   logic [15:0]          romrd_q;
`ifdef ROM_CACHE_STATS_EN
   logic [31:0]          stat_hits;
   logic [31:0]          stat_misses;

   modport slave (
      input  cpu_rd, cpu_a, flush, snoop_we, snoop_a, romrd_ack, romrd_q,
      output cpu_q, cpu_valid, cpu_busy, romrd_req, romrd_a,
      output stat_hits, stat_misses
   );

   modport master (
      output cpu_rd, cpu_a, flush, snoop_we, snoop_a, romrd_ack, romrd_q,
      input  cpu_q, cpu_valid, cpu_busy, romrd_req, romrd_a,
      input  stat_hits, stat_misses
   );
`else
   modport slave (
      input  cpu_rd, cpu_a, flush, snoop_we, snoop_a, romrd_ack, romrd_q,
      output cpu_q, cpu_valid, cpu_busy, romrd_req, romrd_a
   );

   modport master (
      output cpu_rd, cpu_a, flush, snoop_we, snoop_a, romrd_ack, romrd_q,
      input  cpu_q, cpu_valid, cpu_busy, romrd_req, romrd_a
   );
`endif

endinterface

// File: rtl/rom_cache_tagram.sv
// Valid/tag/data line storage: one synchronous fill port, one valid-clear
// port (clear wins on the same index) and two combinational lookups.
module rom_cache_tagram
   import rom_cache_pkg::*;
   #(parameter int IDX_BITS  = DEF_IDX_BITS,
     parameter int ADDR_BITS = DEF_ADDR_BITS,
     localparam int TW       = tagWidth(IDX_BITS, ADDR_BITS))
   (
   input  logic                clk,
   input  logic                i_we,
   input  logic [IDX_BITS-1:0] i_wIdx,
   input  logic [TW-1:0]       i_wTag,
   input  logic [15:0]         i_wData,
   input  logic                i_clr,
   input  logic [IDX_BITS-1:0] i_clrIdx,
   input  logic [IDX_BITS-1:0] i_lkIdx,
   output logic                o_lkValid,
   output logic [TW-1:0]       o_lkTag,
   output logic [15:0]         o_lkData,
   input  logic [IDX_BITS-1:0] i_snIdx,
   output logic                o_snValid,
   output logic [TW-1:0]       o_snTag
   );

   localparam int LINES = 1 << IDX_BITS;

   logic            r_valid [LINES];
   logic [TW-1:0]   r_tag   [LINES];
   logic [15:0]     r_data  [LINES];

   // No reset on the valid bits: the controller always flushes every line before use.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_valid[i_wIdx] <= 1'b1;
      end
      if (i_clr) begin
         r_valid[i_clrIdx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_tag[i_wIdx]  <= i_wTag;
         r_data[i_wIdx] <= i_wData;
      end
   end

   assign o_lkValid = r_valid[i_lkIdx];
   assign o_lkTag   = r_tag[i_lkIdx];
   assign o_lkData  = r_data[i_lkIdx];
   assign o_snValid = r_valid[i_snIdx];
   assign o_snTag   = r_tag[i_snIdx];

endmodule

// File: rtl/rom_read_cache.sv
// Direct-mapped one-word-per-line read cache in front of the SDRAM romrd port.
// Define ROM_CACHE_STATS_EN to add saturating hit/miss counters.
module rom_read_cache
   import rom_cache_pkg::*;
   #(parameter int IDX_BITS  = DEF_IDX_BITS,
     parameter int ADDR_BITS = DEF_ADDR_BITS)
   (
   input  logic            clk,
   input  logic            reset,
   rom_read_cache_if.slave bus
   );

   localparam int TW = tagWidth(IDX_BITS, ADDR_BITS);
   localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};

   state_t                r_state;
   state_t                w_next;
   logic [IDX_BITS-1:0]   r_flushIdx;
   logic                  r_flushPend;
   logic                  r_cpuValid;
   logic [15:0]           r_cpuQ;
   logic                  r_romrdReq;
   logic [ADDR_BITS-1:0]  r_romrdA;

   logic [IDX_BITS-1:0]   w_cpuIdx, w_snpIdx, w_fillIdx, w_clrIdx;
   logic [TW-1:0]         w_cpuTag, w_snpTag, w_fillTag;
   logic                  w_lkValid, w_snValid;
   logic [TW-1:0]         w_lkTag, w_snTag;
   logic [15:0]           w_lkData;
   logic                  w_hit, w_ackDone, w_accept, w_issue, w_fill;
   logic                  w_snoopOn, w_snoopClr, w_clr;

   assign w_cpuIdx  = bus.cpu_a[IDX_BITS-1:0];
   assign w_cpuTag  = bus.cpu_a[ADDR_BITS-1:IDX_BITS];
   assign w_snpIdx  = bus.snoop_a[IDX_BITS-1:0];
   assign w_snpTag  = bus.snoop_a[ADDR_BITS-1:IDX_BITS];
   assign w_fillIdx = r_romrdA[IDX_BITS-1:0];
   assign w_fillTag = r_romrdA[ADDR_BITS-1:IDX_BITS];

   assign w_hit     = w_lkValid && (w_lkTag == w_cpuTag);
   assign w_ackDone = (bus.romrd_ack == r_romrdReq);
   assign w_accept  = (r_state == IDLE) && bus.cpu_rd && !bus.flush;
   assign w_issue   = w_accept && !w_hit;
   assign w_fill    = (r_state == MISS) && w_ackDone;

   // A fill landing on the snooped index replaces the stored line, so only the
   // incoming tag matters there; the clear then beats the fill's valid set.
   assign w_snoopOn  = bus.snoop_we && (r_state != FLUSH) && (r_state != DRAIN);
   assign w_snoopClr = w_snoopOn &&
                       ((w_fill && (w_fillIdx == w_snpIdx)) ? (w_fillTag == w_snpTag)
                                                            : (w_snValid && (w_snTag == w_snpTag)));
   assign w_clr      = (r_state == FLUSH) || w_snoopClr;
   assign w_clrIdx   = (r_state == FLUSH) ? r_flushIdx : w_snpIdx;

   rom_cache_tagram #(
      .IDX_BITS  (IDX_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_tagram (
      .clk       (clk),
      .i_we      (w_fill),
      .i_wIdx    (w_fillIdx),
      .i_wTag    (w_fillTag),
      .i_wData   (bus.romrd_q),
      .i_clr     (w_clr),
      .i_clrIdx  (w_clrIdx),
      .i_lkIdx   (w_cpuIdx),
      .o_lkValid (w_lkValid),
      .o_lkTag   (w_lkTag),
      .o_lkData  (w_lkData),
      .i_snIdx   (w_snpIdx),
      .o_snValid (w_snValid),
      .o_snTag   (w_snTag)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         DRAIN:   if (w_ackDone) w_next = FLUSH;
         FLUSH:   if (r_flushIdx == LAST_IDX) w_next = IDLE;
         IDLE: begin
            if (bus.flush)    w_next = FLUSH;
            else if (w_issue) w_next = MISS;
         end
         MISS:    if (w_ackDone) w_next = RESP;
         RESP:    w_next = (r_flushPend || bus.flush) ? FLUSH : IDLE;
         default: w_next = DRAIN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= DRAIN;
         r_flushIdx  <= '0;
         r_flushPend <= 1'b0;
         r_cpuValid  <= 1'b0;
         r_cpuQ      <= '0;
         r_romrdA    <= '0;
      end else begin
         r_state    <= w_next;
         r_cpuValid <= (w_accept && w_hit) || w_fill;
         if (r_state == FLUSH) begin
            r_flushIdx <= r_flushIdx + 1'b1;
         end
         if (w_next == FLUSH) begin
            r_flushPend <= 1'b0;
         end else if (bus.flush && ((r_state == MISS) || (r_state == RESP))) begin
            r_flushPend <= 1'b1;
         end
         if (w_accept && w_hit) begin
            r_cpuQ <= w_lkData;
         end else if (w_fill) begin
            r_cpuQ <= bus.romrd_q;
         end
         if (w_issue) begin
            r_romrdA <= bus.cpu_a;
         end
      end
   end

   // The request toggle survives reset so an in-flight controller read still pairs up.
   always_ff @(posedge clk) begin
      if (!reset && w_issue) begin
         r_romrdReq <= ~r_romrdReq;
      end
   end

   assign bus.cpu_q     = r_cpuQ;
   assign bus.cpu_valid = r_cpuValid;
   assign bus.cpu_busy  = (r_state != IDLE);
   assign bus.romrd_req = r_romrdReq;
   assign bus.romrd_a   = r_romrdA;

`ifdef ROM_CACHE_STATS_EN
   logic [31:0] r_statHits;
   logic [31:0] r_statMisses;

   always_ff @(posedge clk) begin
      if (reset || (r_state == FLUSH)) begin
         r_statHits   <= '0;
         r_statMisses <= '0;
      end else begin
         if (w_accept && w_hit && (r_statHits != 32'hFFFF_FFFF)) begin
            r_statHits <= r_statHits + 32'd1;
         end
         if (w_issue && (r_statMisses != 32'hFFFF_FFFF)) begin
            r_statMisses <= r_statMisses + 32'd1;
         end
      end
   end

   assign bus.stat_hits   = r_statHits;
   assign bus.stat_misses = r_statMisses;
`endif

endmodule

// File: tb/tb_rom_read_cache.sv
// Directed bench for rom_read_cache: cold start, hits, aliasing, snoops,
// flush during a miss and reset during an outstanding romrd read.
module tb_rom_read_cache;

   logic clk = 1'b0;
   logic reset;
   int   checkCount = 0;
   int   errorCount = 0;
   logic expReq = 1'b0;
   int   busyCycles;

   rom_read_cache_if #(.ADDR_BITS(23)) bus ();

   rom_read_cache #(.IDX_BITS(6), .ADDR_BITS(23)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of strobes; returns at the negedge after they were sampled.
   task automatic applyStimulus(input logic rd, input logic [22:0] a, input logic fl,
                                input logic sw, input logic [22:0] sa);
      bus.cpu_rd   = rd;
      bus.cpu_a    = a;
      bus.flush    = fl;
      bus.snoop_we = sw;
      bus.snoop_a  = sa;
      @(negedge clk);
      bus.cpu_rd   = 1'b0;
      bus.flush    = 1'b0;
      bus.snoop_we = 1'b0;
   endtask

   task automatic countBusy(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         if (!bus.cpu_busy) break;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic readHit(input string name, input logic [22:0] a, input logic [15:0] d);
      applyStimulus(1'b1, a, 1'b0, 1'b0, 23'd0);
      checkOutput({name, "_valid"}, {31'd0, bus.cpu_valid}, 32'd1);
      checkOutput({name, "_q"}, {16'd0, bus.cpu_q}, {16'd0, d});
      checkOutput({name, "_noToggle"}, {31'd0, bus.romrd_req}, {31'd0, expReq});
   endtask

   task automatic readMiss(input string name, input logic [22:0] a, input logic [15:0] d,
                           input int delay, input logic flushMid, input logic snoopAtAck);
      applyStimulus(1'b1, a, 1'b0, 1'b0, 23'd0);
      expReq = ~expReq;
      checkOutput({name, "_req"}, {31'd0, bus.romrd_req}, {31'd0, expReq});
      checkOutput({name, "_addr"}, {9'd0, bus.romrd_a}, {9'd0, a});
      checkOutput({name, "_busy"}, {31'd0, bus.cpu_busy}, 32'd1);
      for (int i = 0; i < delay; i++) begin
         bus.flush = flushMid && (i == 2);
         @(negedge clk);
      end
      bus.flush = 1'b0;
      checkOutput({name, "_noEarlyValid"}, {31'd0, bus.cpu_valid}, 32'd0);
      bus.romrd_q   = d;
      bus.romrd_ack = expReq;
      bus.snoop_we  = snoopAtAck;
      bus.snoop_a   = a;
      @(negedge clk);
      bus.snoop_we  = 1'b0;
      checkOutput({name, "_valid"}, {31'd0, bus.cpu_valid}, 32'd1);
      checkOutput({name, "_q"}, {16'd0, bus.cpu_q}, {16'd0, d});
      @(negedge clk);
      checkOutput({name, "_pulseEnd"}, {31'd0, bus.cpu_valid}, 32'd0);
      checkOutput({name, "_busyAfter"}, {31'd0, bus.cpu_busy}, {31'd0, flushMid});
   endtask

   initial begin
      reset         = 1'b1;
      bus.cpu_rd    = 1'b0;
      bus.cpu_a     = '0;
      bus.flush     = 1'b0;
      bus.snoop_we  = 1'b0;
      bus.snoop_a   = '0;
      bus.romrd_ack = 1'b0;
      bus.romrd_q   = '0;

      // Cold start
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {31'd0, bus.cpu_busy}, 32'd1);
      checkOutput("rst_valid", {31'd0, bus.cpu_valid}, 32'd0);
      checkOutput("rst_q", {16'd0, bus.cpu_q}, 32'd0);
      checkOutput("rst_romrdA", {9'd0, bus.romrd_a}, 32'd0);
      reset = 1'b0;
      countBusy(busyCycles);
      checkOutput("cold_busyCycles", busyCycles, 32'd65);

      readMiss("cold_miss", 23'h000100, 16'hBEEF, 9, 1'b0, 1'b0);
      readHit("reread_hit", 23'h000100, 16'hBEEF);

      // Alias on index 0
      readMiss("alias_miss", 23'h000140, 16'h1234, 3, 1'b0, 1'b0);
      readHit("alias_hit", 23'h000140, 16'h1234);
      readMiss("alias_back", 23'h000100, 16'hBEEF, 2, 1'b0, 1'b0);

      // Snoops
      applyStimulus(1'b0, 23'd0, 1'b0, 1'b1, 23'h000102);
      readHit("snoopOther_hit", 23'h000100, 16'hBEEF);
      applyStimulus(1'b0, 23'd0, 1'b0, 1'b1, 23'h000100);
      readMiss("snoop_miss", 23'h000100, 16'hBEEF, 4, 1'b0, 1'b0);
      readMiss("line5_miss", 23'h000205, 16'h5555, 1, 1'b0, 1'b0);
      applyStimulus(1'b1, 23'h000205, 1'b0, 1'b1, 23'h000205);
      checkOutput("snoopHit_valid", {31'd0, bus.cpu_valid}, 32'd1);
      checkOutput("snoopHit_oldQ", {16'd0, bus.cpu_q}, 32'h5555);
      readMiss("snoopHit_refill", 23'h000205, 16'h5A5A, 2, 1'b0, 1'b0);
      readHit("line5_hit", 23'h000205, 16'h5A5A);

      // Snoop racing a fill of the same line
      readMiss("race_fill", 23'h000007, 16'h7777, 3, 1'b0, 1'b1);
      readMiss("race_after", 23'h000007, 16'h7878, 2, 1'b0, 1'b0);
      readHit("race_hit", 23'h000007, 16'h7878);

      // Flush during a miss
      readMiss("flushMid", 23'h000003, 16'h0C0C, 6, 1'b1, 1'b0);
      countBusy(busyCycles);
      checkOutput("flush_busyCycles", busyCycles, 32'd64);
      readMiss("postFlush_100", 23'h000100, 16'hBEEF, 1, 1'b0, 1'b0);
      readMiss("postFlush_205", 23'h000205, 16'h5A5A, 1, 1'b0, 1'b0);
      readMiss("postFlush_003", 23'h000003, 16'h0C0C, 1, 1'b0, 1'b0);

      // Reset while a read is outstanding
      applyStimulus(1'b1, 23'h000010, 1'b0, 1'b0, 23'd0);
      expReq = ~expReq;
      checkOutput("rstMid_req", {31'd0, bus.romrd_req}, {31'd0, expReq});
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("rstMid_busy", {31'd0, bus.cpu_busy}, 32'd1);
      checkOutput("rstMid_q", {16'd0, bus.cpu_q}, 32'd0);
      checkOutput("rstMid_romrdA", {9'd0, bus.romrd_a}, 32'd0);
      repeat (5) @(negedge clk);
      checkOutput("rstMid_drainBusy", {31'd0, bus.cpu_busy}, 32'd1);
      checkOutput("rstMid_noToggle", {31'd0, bus.romrd_req}, {31'd0, expReq});
      bus.romrd_q   = 16'hDEAD;
      bus.romrd_ack = expReq;
      @(negedge clk);
      checkOutput("rstMid_noValid", {31'd0, bus.cpu_valid}, 32'd0);
      countBusy(busyCycles);
      checkOutput("rstMid_busyCycles", busyCycles, 32'd64);
      readMiss("rstMid_first", 23'h000100, 16'hCAFE, 2, 1'b0, 1'b0);
      readHit("rstMid_hit", 23'h000100, 16'hCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/rom_read_cache.md
Name: rom_read_cache

Overview:
- Direct-mapped, single-word-per-line read cache between the 68k cartridge ROM bus decoder and the SDRAM controller's ROM read port.
- Hits return in one cycle; misses issue one toggle-handshake read on the controller's romrd port and fill the line.
- ROM writes from the loader are snooped so that cached data never goes stale.
- A full flush, sequenced one line per cycle, runs on reset and on demand.

Parameters:
- IDX_BITS, 6, log2 of line count (64 lines default).
- ADDR_BITS, 23, word-address width (address bits [23:1]).

Ports:
- clk  in  1  system/SDRAM clock.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  one-cycle read strobe; only legal while cpu_busy=0.
- cpu_a  in  23  word address [23:1], sampled with cpu_rd.
- cpu_q  out  16  read data, valid when cpu_valid=1, held until the next cpu_valid.
- cpu_valid  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high while a request, flush or drain is in progress.
- flush  in  1  one-cycle strobe requesting invalidation of all lines.
- snoop_we  in  1  one-cycle strobe: ROM word written at snoop_a.
- snoop_a  in  23  address of the ROM write.
- romrd_req  out  1  toggle request to the SDRAM controller.
- romrd_ack  in  1  controller acknowledge; equal to romrd_req means done.
- romrd_a  out  23  word address, stable while romrd_req != romrd_ack.
- romrd_q  in  16  data, valid when romrd_ack == romrd_req after a toggle.

Behaviour:
- Storage: valid[2^IDX_BITS], tag[ADDR_BITS-IDX_BITS], data[16] per line. Index = cpu_a[IDX_BITS:1], tag = upper address bits.
- States: DRAIN, FLUSH, IDLE, MISS, RESP.
- Reset:
  - state=DRAIN, flush index=0, cpu_valid=0, cpu_busy=1, cpu_q=0, romrd_a=0, pending flush cleared.
  - romrd_req is not modified by reset; the toggle relation with the controller must be preserved.
- DRAIN: wait until romrd_ack==romrd_req, which completes any read outstanding before reset. Then go to FLUSH.
- FLUSH:
  - Clear valid[idx], idx++.
  - At idx==2^IDX_BITS-1, clear it, wrap idx to 0, go to IDLE.
  - Takes exactly 2^IDX_BITS cycles.
- IDLE:
  - cpu_busy=0.
  - flush strobe: go to FLUSH; takes priority over a simultaneous cpu_rd, which is dropped (caller must not strobe with flush).
  - cpu_rd on hit: next cycle cpu_valid=1 and cpu_q=line data. Latency 1.
  - cpu_rd on miss: next cycle romrd_a=cpu_a, romrd_req toggles, go to MISS.
- MISS:
  - When romrd_ack==romrd_req, write data/tag, set valid, cpu_q=romrd_q.
  - Go to RESP, which issues the cpu_valid pulse one cycle after the ack is observed.
- RESP: cpu_valid=1 for one cycle. Then go to FLUSH if a flush is pending, otherwise IDLE.
- flush strobe while busy (MISS/RESP) is latched as pending. The current miss completes and returns data, then the FLUSH runs.
- Snoop, in any state except FLUSH/DRAIN:
  - If valid[snoop index] and tag matches, clear that valid bit the next cycle.
  - Snoop in the same cycle as a fill to the same index and tag: the fill data is still returned to the CPU, but the line stays invalid (snoop wins).
  - Snoop in the same cycle as a hit lookup at the same address: the hit returns old data and the line is invalidated.
  - During FLUSH/DRAIN, snoops are ignored; all lines end up invalid regardless.
- cpu_busy=1 in every state except IDLE.
- cpu_rd while busy is a protocol violation; it is ignored.

Optional Feature:
- Macro ROM_CACHE_STATS_EN.
- With it defined:
  - Adds outputs stat_hits[31:0] and stat_misses[31:0].
  - The counters increment on each accepted hit and each miss respectively, saturate at 32'hFFFFFFFF, and clear on reset or flush.
- Without it: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package rom_cache_pkg:
  - state enum (DRAIN, FLUSH, IDLE, MISS, RESP).
  - IDX_BITS/ADDR_BITS defaults.
  - tag width function.
- One sub-module: rom_cache_tagram, holding valid/tag/data storage with a synchronous write port, a one-cycle clear port and a combinational lookup.

Test Plan:
- Cold start: reset for 2 cycles, then check cpu_busy=1 for 1+64 cycles. Read 0x000100 → miss, romrd_a=0x000100, romrd_req toggles. Bench acks after 9 cycles with 0xBEEF → cpu_valid one cycle after the ack, cpu_q=0xBEEF.
- Re-read 0x000100 → cpu_valid the next cycle, 0xBEEF, and no romrd_req toggle.
- Alias: read 0x000140 (same index, different tag) → miss and refill. A following read of 0x000100 misses again.
- Snoop: after 0x000100 is cached, snoop_we at 0x000100 → the next read of 0x000100 misses. Snoop at 0x000102 leaves 0x000100 a hit.
- Flush during a miss: toggle outstanding, flush strobe → the miss completes with data, then cpu_busy stays high for 64 cycles, and all previously cached addresses miss.
- Reset mid-miss: assert reset while req!=ack → no new toggle until the bench acks. Then a 64-cycle flush runs, IDLE is reached, and the first read misses.
